// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: CPU width,
// instruction memory depth and loader FSM state encodings.
package imem_boot_loader_pkg;

  localparam int CPU_W      = 32;
  localparam int IMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IMEM_LD_IDLE  = 2'd0,
    IMEM_LD_LOAD  = 2'd1,
    IMEM_LD_FLUSH = 2'd2,
    IMEM_LD_RUN   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/imem_boot_loader.sv
// Shares the instruction memory port between a boot-time word loader and CPU
// fetch; loaded words pass through a one-stage registered write pipeline.
//
// state | meaning
// IDLE  | after reset, core held, waiting for load_start_i
// LOAD  | accepting words, writing consecutive word addresses from 0
// FLUSH | one cycle for the last accepted word to drain to memory
// RUN   | port owned by cpu_pc_i, core released
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter  int DATA_W = CPU_W,
  parameter  int DEPTH  = IMEM_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  input  logic [DATA_W-1:0] cpu_pc_i,
  output logic              cpu_hold_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              wr_vld_q, wr_vld_d;
  logic [DATA_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IMEM_LD_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    wr_vld_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    err_d      = err_q;
    ready      = 1'b0;
    cpu_hold_o = 1'b1;

    unique case (state_q)
      IMEM_LD_IDLE, IMEM_LD_RUN: begin
        cpu_hold_o = (state_q != IMEM_LD_RUN);
        if (load_start_i) begin
          if (load_len_i == '0) begin
            state_d = IMEM_LD_RUN;
            done_d  = 1'b1;
          end else if (load_len_i > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            len_d   = load_len_i;
            cnt_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = IMEM_LD_LOAD;
          end
        end
      end
      IMEM_LD_LOAD: begin
        // ready depends only on registers so the source may wait on it
        ready = (cnt_q < len_q);
        if (ld_valid_i && ready) begin
          wr_vld_d                 = 1'b1;
          wr_addr_d                = '0;
          wr_addr_d[ADDR_W+2:0]    = {cnt_q, 2'b00};
          wr_data_d                = ld_data_i;
          cnt_d                    = cnt_q + ONE_L;
          if (cnt_q + ONE_L == len_q) state_d = IMEM_LD_FLUSH;
        end
      end
      IMEM_LD_FLUSH: begin
        state_d = IMEM_LD_RUN;
        done_d  = 1'b1;
      end
      default: state_d = IMEM_LD_IDLE;
    endcase
  end

  assign ld_ready_o  = ready;
  assign mem_wr_en_o = wr_vld_q;
  assign mem_addr_o  = (state_q == IMEM_LD_RUN) ? cpu_pc_i : wr_addr_q;
  assign mem_data_o  = wr_data_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences the instruction memory's single address/write port between a boot-time word loader and CPU instruction fetch.
- Accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive word addresses from 0 through a one-stage registered write pipeline.
- Holds the CPU in stall while loading, then hands the port to the fetch PC.
- Sits between the boot source (testbench or UART front-end) and the instruction memory, beside the core's fetch stage.

Parameters:
- DATA_W, 32, instruction/data width; equals the CPU width.
- DEPTH, 256, instruction memory depth in words; must be a power of two.
- ADDR_W, log2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start_i  in  1  single-cycle pulse requesting a (re)load.
- load_len_i  in  ADDR_W+1  number of words to load; sampled with load_start_i.
- ld_valid_i  in  1  loader word valid.
- ld_data_i  in  DATA_W  loader word.
- ld_ready_o  out  1  block accepts a word this cycle.
- cpu_pc_i  in  DATA_W  fetch byte address from the core.
- cpu_hold_o  out  1  stall/hold for the core; 1 while not in RUN.
- mem_wr_en_o  out  1  write enable to instruction memory.
- mem_addr_o  out  DATA_W  byte address to instruction memory.
- mem_data_o  out  DATA_W  write data to instruction memory.
- load_done_o  out  1  sticky; last load completed.
- load_err_o  out  1  sticky; illegal load_len_i requested.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE; cnt = 0; len_q = 0.
  - Write register cleared: wr_vld_q = 0, wr_addr_q = 0, wr_data_q = 0.
  - Outputs: cpu_hold_o = 1, ld_ready_o = 0, mem_wr_en_o = 0, load_done_o = 0, load_err_o = 0.
- States: IDLE, LOAD, FLUSH, RUN.
- IDLE, on load_start_i:
  - load_len_i == 0: go to RUN; load_done_o = 1.
  - load_len_i > DEPTH: set load_err_o, stay in IDLE.
  - Otherwise: len_q = load_len_i, cnt = 0, clear load_done_o and load_err_o, go to LOAD.
- LOAD:
  - ld_ready_o = (cnt < len_q); driven from state and registers only, with no combinational path from ld_valid_i.
  - On a handshake (ld_valid_i && ld_ready_o): wr_vld_q <= 1, wr_addr_q <= {cnt, 2'b00}, wr_data_q <= ld_data_i, cnt <= cnt + 1.
  - With no handshake: wr_vld_q <= 0.
  - When the handshake accepts word cnt == len_q - 1, go to FLUSH.
- FLUSH:
  - Lasts exactly one cycle; the final write drains through the registered pipeline.
  - wr_vld_q <= 0; go to RUN; load_done_o <= 1.
- RUN:
  - cpu_hold_o = 0; ld_ready_o = 0.
  - load_start_i follows the IDLE rules. A legal request re-enters LOAD with cpu_hold_o = 1 from the next cycle; len == 0 stays in RUN; an illegal length sets load_err_o and stays in RUN.
- Port mux (combinational):
  - mem_wr_en_o = wr_vld_q.
  - mem_addr_o = cpu_pc_i in RUN, otherwise wr_addr_q.
  - mem_data_o = wr_data_q.
- Latency: a word accepted at cycle N is written to memory at the clock edge ending cycle N+1.
- Back-to-back words are accepted at 1 per cycle.
- load_start_i asserted during LOAD or FLUSH is ignored.
- Bubbles on ld_valid_i only stretch LOAD; the address sequence stays contiguous.
- Address width: cnt is ADDR_W+1 bits. Byte address = cnt zero-extended to DATA_W and shifted left by 2; it never wraps because len_q <= DEPTH.
- Reset asserted mid-load: state returns to IDLE immediately and any pending write is dropped. Memory contents are undefined; a reload is required.

Decomposition:
- Shared defines file (existing global defines):
  - CPU width.
  - Instruction memory depth.
  - State encodings: IMEM_LD_IDLE = 2'd0, IMEM_LD_LOAD = 2'd1, IMEM_LD_FLUSH = 2'd2, IMEM_LD_RUN = 2'd3.
- No sub-module is needed; the FSM, counter, write register and port mux fit in one module.
- The top level instantiates this block beside the instruction memory.

Test Plan:
1. Reset, then load_start_i with len = 4 and words 0x00000013, 0x00100093, 0x00200113, 0x00300193 on back-to-back ld_valid_i -> writes at addresses 0x0, 0x4, 0x8, 0xC, one cycle after each accept; load_done_o = 1 and cpu_hold_o = 0 two cycles after the last accept; memory readback matches.
2. Same load with ld_valid_i low for 3 cycles between words 2 and 3 -> no write during the gap; addresses stay contiguous; final contents identical to scenario 1.
3. load_len_i = DEPTH + 1 = 257 -> load_err_o = 1, state stays IDLE, cpu_hold_o stays 1, no write occurs; load_len_i = 0 -> RUN immediately with load_done_o = 1.
4. In RUN, drive cpu_pc_i = 0x8 -> mem_addr_o = 0x8 with mem_wr_en_o = 0; then pulse load_start_i with len = 2 -> cpu_hold_o = 1 from the next cycle, load_done_o cleared, reload writes 0x0 and 0x4.
5. Pulse load_start_i again mid-LOAD -> ignored; len_q and cnt unchanged; the original load completes.
6. Assert rst_n low after 2 of 4 words are accepted -> all outputs return to reset values asynchronously; after release, a fresh len = 4 load completes correctly.
